fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//   Instruction-fetch (IF) stage of the 5-stage MIPS pipeline, directly upstream of instructionmemory.
//   Holds the PC and drives the word index into the combinational instruction memory.
//   Captures the returned instruction into the IF/ID pipeline register.
//   Handles PC+4 sequencing, hazard stalls and branch/jump redirects, flushing the wrong-path instruction.
// PARAMETERS
//   DW        32          data/PC width (matches instructionmemory CSIZE+1)
//   IMEM_AW   5           word-index bits presented to instruction memory (32 words)
//   RESET_PC  32'h0       byte address loaded into PC on reset
//   NOP       32'h0       instruction injected into IF/ID on reset/flush (sll $0,$0,0)
// PORTS
//   clk         in   1       rising-edge clock
//   rst         in   1       synchronous, active-high reset
//   stall       in   1       hazard unit: hold PC and IF/ID contents
//   br_taken    in   1       EX-stage branch resolved taken
//   br_target   in   DW      branch target byte address
//   jmp         in   1       ID-stage jump decoded
//   jmp_target  in   DW      jump target byte address
//   imem_addr   out  DW      word index to instruction memory = {0, pc[IMEM_AW+1:2]}
//   imem_data   in   DW      instruction returned combinationally by instruction memory
//   if_pc       out  DW      current PC (byte address)
//   ifid_instr  out  DW      IF/ID registered instruction
//   ifid_pc4    out  DW      IF/ID registered PC+4 of that instruction
//   ifid_valid  out  1       IF/ID holds a real (non-flushed) instruction
// BEHAVIOUR
//   - Reset (sync, rst=1 at posedge): pc<=RESET_PC; ifid_instr<=NOP; ifid_pc4<=0; ifid_valid<=0.
//   - Reset overrides every other input; rst asserted mid-stall or mid-redirect discards that event.
//   - imem_addr is combinational from pc; the instruction is sampled the same cycle, so fetch latency is 1 clk
//     (PC to ifid_instr).
//   - Priority per cycle: rst > br_taken > jmp > stall > sequential.
//   - br_taken: pc<=br_target&~3; IF/ID<=NOP, valid 0. Branch is older than jmp, so an ID jump in the
//     same cycle is squashed.
//   - jmp (no br_taken): pc<=jmp_target&~3; IF/ID<=NOP, valid 0 (delay slot not supported).
//   - Redirect overrides stall: PC loads the target and IF/ID flushes even while stall=1.
//   - stall (no redirect): pc, ifid_instr, ifid_pc4 and ifid_valid all hold; imem_addr stays constant.
//   - Sequential: pc<=pc+4; ifid_instr<=imem_data; ifid_pc4<=pc+4; ifid_valid<=1.
//   - Arithmetic: pc+4 is modulo 2^DW (32'hFFFF_FFFC -> 32'h0).
//   - imem_addr uses only pc[IMEM_AW+1:2], so fetch wraps every 2^IMEM_AW words
//     (byte addr 0x80 reads word 0).
//   - Target bits [1:0] are forced to 0, so misaligned targets are never fetched.
//   - State: PC register plus IF/ID register. No FSM beyond reset/run; no handshake with memory
//     (memory is always ready).
// CONFIGURATION
//   FETCH_PERF_CNT_EN defined:
//     - adds outputs fetch_cnt, stall_cnt, flush_cnt (each DW bits).
//     - All reset to 0.
//     - On a sequential cycle fetch_cnt+1; on a stall (no redirect) stall_cnt+1; on a redirect flush_cnt+1.
//     - Exactly one counter increments per non-reset cycle.
//     - Counters wrap modulo 2^DW.
//   FETCH_PERF_CNT_EN undefined:
//     - counter logic and ports are absent; all other behaviour is identical.
// TESTING
//   1 Reset: rst=1 two cycles -> pc=0, imem_addr=0, ifid_instr=NOP, ifid_valid=0; release -> pc 0,4,8,12 on successive clks.
//   2 Sequential fetch: mem[0..3]=A,B,C,D -> ifid_instr A,B,C,D with ifid_pc4 4,8,12,16, valid=1.
//   3 Stall: stall=1 for 3 clks at pc=8 -> pc stays 8, ifid_instr stays B, imem_addr=2; release -> C captured, pc=12.
//   4 Redirects: br_taken=1,br_target=0x40 with jmp=1,jmp_target=0x20 in the same clk ->
//     pc=0x40, ifid_valid=0, ifid_instr=NOP.
//     Next, jmp alone to 0x22 -> pc=0x20.
//     Next, br_taken with stall=1 -> redirect taken.
//   5 Wrap: pc=0x7C -> next imem_addr=0 (pc=0x80); with RESET_PC=32'hFFFF_FFFC -> pc becomes 0 after one clk.
//   6 Mid-op reset, with FETCH_PERF_CNT_EN defined: 5 fetch, 2 stall, 1 flush -> counts 5/2/1.
//     Then rst=1 during stall+br_taken -> pc=RESET_PC, all counters 0, ifid_valid=0.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, instruction-memory word index, IF/ID pipeline register.
// Latency: 1 clk from PC to ifid_instr. Instruction memory is combinational and always ready.
// Backpressure: stall holds PC and IF/ID. A redirect (branch or jump) overrides stall and flushes IF/ID.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   stall             hold PC and IF/ID contents (hazard unit)
//   br_taken/target   EX-stage taken branch and its byte target (highest redirect priority)
//   jmp/jmp_target    ID-stage jump and its byte target
//   imem_addr         word index into instruction memory, {0, pc[IMEM_AW+1:2]}
//   imem_data         instruction returned combinationally for imem_addr
//   if_pc             current fetch PC (byte address)
//   ifid_instr/pc4    IF/ID instruction and the PC+4 of that instruction
//   ifid_valid        IF/ID holds a real (non-flushed) instruction
//   fetch_cnt, stall_cnt, flush_cnt
//                     performance counters, present only when FETCH_PERF_CNT_EN is defined
//
// Build option: FETCH_PERF_CNT_EN adds the three wrapping performance counters.
module fetch_stage #(
  parameter int          DW       = 32,
  parameter int          IMEM_AW  = 5,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter logic [31:0] NOP      = 32'h0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          br_taken,
  input  logic [DW-1:0] br_target,
  input  logic          jmp,
  input  logic [DW-1:0] jmp_target,
  output logic [DW-1:0] imem_addr,
  input  logic [DW-1:0] imem_data,
  output logic [DW-1:0] if_pc,
  output logic [DW-1:0] ifid_instr,
  output logic [DW-1:0] ifid_pc4,
  output logic          ifid_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [DW-1:0] fetch_cnt,
  output logic [DW-1:0] stall_cnt,
  output logic [DW-1:0] flush_cnt
`endif
);

  // Clears the byte-offset bits of a redirect target so fetch stays word aligned.
  localparam logic [DW-1:0] ALIGN_MASK = ~DW'(3);
  localparam logic [DW-1:0] PC_INIT    = DW'(RESET_PC);
  localparam logic [DW-1:0] NOP_INSTR  = DW'(NOP);

  logic [DW-1:0] pc;
  logic [DW-1:0] pc4;
  logic          redirect;
  logic [DW-1:0] redirect_pc;
  logic          advance;

  // pc+4 wraps naturally at 2^DW.
  assign pc4 = pc + DW'(4);

  // Only the low word-index bits reach memory, so fetch aliases every 2^IMEM_AW words.
  assign imem_addr = {{(DW-IMEM_AW){1'b0}}, pc[IMEM_AW+1:2]};
  assign if_pc     = pc;

  // The branch is resolved in EX and is older than a jump decoded in ID, so it wins.
  assign redirect    = br_taken | jmp;
  assign redirect_pc = (br_taken ? br_target : jmp_target) & ALIGN_MASK;
  assign advance     = ~redirect & ~stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc         <= PC_INIT;
      ifid_instr <= NOP_INSTR;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
    end else if (redirect) begin
      // Redirect beats stall: the instruction in IF is on the wrong path either way.
      pc         <= redirect_pc;
      ifid_instr <= NOP_INSTR;
      ifid_pc4   <= '0;
      ifid_valid <= 1'b0;
    end else if (advance) begin
      pc         <= pc4;
      ifid_instr <= imem_data;
      ifid_pc4   <= pc4;
      ifid_valid <= 1'b1;
    end
    // Otherwise stall: PC and IF/ID hold.
  end

`ifdef FETCH_PERF_CNT_EN
  // Exactly one counter moves on every non-reset cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (redirect) begin
      flush_cnt <= flush_cnt + DW'(1);
    end else if (stall) begin
      stall_cnt <= stall_cnt + DW'(1);
    end else begin
      fetch_cnt <= fetch_cnt + DW'(1);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic        jmp;
  logic [31:0] jmp_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_pc;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc4;
  logic        ifid_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, stall_cnt, flush_cnt;
  logic [31:0] w_fetch_cnt, w_stall_cnt, w_flush_cnt;
`endif

  // Second instance exercising the PC wrap out of a top-of-space reset vector.
  logic        w_rst;
  logic [31:0] w_imem_addr, w_if_pc, w_ifid_instr, w_ifid_pc4;
  logic        w_ifid_valid;

  logic [31:0] mem [32];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign imem_data = mem[imem_addr[4:0]];

  fetch_stage #(.DW(32), .IMEM_AW(5), .RESET_PC(32'h0), .NOP(32'h0)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .jmp        (jmp),
    .jmp_target (jmp_target),
    .imem_addr  (imem_addr),
    .imem_data  (imem_data),
    .if_pc      (if_pc),
    .ifid_instr (ifid_instr),
    .ifid_pc4   (ifid_pc4),
    .ifid_valid (ifid_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt  (fetch_cnt),
    .stall_cnt  (stall_cnt),
    .flush_cnt  (flush_cnt)
`endif
  );

  fetch_stage #(.DW(32), .IMEM_AW(5), .RESET_PC(32'hFFFF_FFFC), .NOP(32'h0)) dut_wrap (
    .clk        (clk),
    .rst        (w_rst),
    .stall      (1'b0),
    .br_taken   (1'b0),
    .br_target  (32'h0),
    .jmp        (1'b0),
    .jmp_target (32'h0),
    .imem_addr  (w_imem_addr),
    .imem_data  (32'h1234_5678),
    .if_pc      (w_if_pc),
    .ifid_instr (w_ifid_instr),
    .ifid_pc4   (w_ifid_pc4),
    .ifid_valid (w_ifid_valid)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt  (w_fetch_cnt),
    .stall_cnt  (w_stall_cnt),
    .flush_cnt  (w_flush_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    stall = 0; br_taken = 0; br_target = 0; jmp = 0; jmp_target = 0;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = 32'hC0DE_0000 + i;
    idle_inputs();
    rst = 1; w_rst = 1;

    // Reset for two cycles.
    tick(); tick();
    chk("rst_pc", if_pc, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_instr", ifid_instr, 32'h0);
    chk("rst_valid", {31'b0, ifid_valid}, 32'h0);
    chk("wrap_rst_pc", w_if_pc, 32'hFFFF_FFFC);
    chk("wrap_rst_addr", w_imem_addr, 32'd31);
    rst = 0; w_rst = 0;

    // Sequential fetch of A, B.
    tick();
    chk("seq0_pc", if_pc, 32'd4);
    chk("seq0_instr", ifid_instr, mem[0]);
    chk("seq0_pc4", ifid_pc4, 32'd4);
    chk("seq0_valid", {31'b0, ifid_valid}, 32'd1);
    chk("wrap_pc", w_if_pc, 32'h0);
    chk("wrap_pc4", w_ifid_pc4, 32'h0);
    chk("wrap_instr", w_ifid_instr, 32'h1234_5678);
    tick();
    chk("seq1_pc", if_pc, 32'd8);
    chk("seq1_instr", ifid_instr, mem[1]);
    chk("seq1_pc4", ifid_pc4, 32'd8);

    // Stall three cycles at pc=8.
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", if_pc, 32'd8);
      chk("stall_instr", ifid_instr, mem[1]);
      chk("stall_addr", imem_addr, 32'd2);
      chk("stall_valid", {31'b0, ifid_valid}, 32'd1);
    end
    stall = 0;
    tick();
    chk("unstall_instr", ifid_instr, mem[2]);
    chk("unstall_pc", if_pc, 32'd12);
    chk("unstall_pc4", ifid_pc4, 32'd12);
    tick();
    chk("seq3_instr", ifid_instr, mem[3]);
    chk("seq3_pc4", ifid_pc4, 32'd16);

    // Branch and jump together: branch wins.
    br_taken = 1; br_target = 32'h40; jmp = 1; jmp_target = 32'h20;
    tick();
    chk("br_pc", if_pc, 32'h40);
    chk("br_valid", {31'b0, ifid_valid}, 32'd0);
    chk("br_instr", ifid_instr, 32'h0);
    // Jump alone to a misaligned target.
    br_taken = 0; jmp = 1; jmp_target = 32'h22;
    tick();
    chk("jmp_pc", if_pc, 32'h20);
    chk("jmp_valid", {31'b0, ifid_valid}, 32'd0);
    // Branch under stall still redirects.
    jmp = 0; br_taken = 1; br_target = 32'h13; stall = 1;
    tick();
    chk("br_stall_pc", if_pc, 32'h10);
    chk("br_stall_valid", {31'b0, ifid_valid}, 32'd0);
    idle_inputs();
    tick();
    chk("post_br_instr", ifid_instr, mem[4]);
    chk("post_br_pc4", ifid_pc4, 32'h14);
    chk("post_br_valid", {31'b0, ifid_valid}, 32'd1);

    // Index wrap at byte address 0x80.
    jmp = 1; jmp_target = 32'h7C;
    tick();
    jmp = 0;
    chk("wrapidx_addr31", imem_addr, 32'd31);
    tick();
    chk("wrapidx_instr", ifid_instr, mem[31]);
    chk("wrapidx_pc", if_pc, 32'h80);
    chk("wrapidx_addr0", imem_addr, 32'd0);
    tick();
    chk("wrapidx_instr0", ifid_instr, mem[0]);
    chk("wrapidx_pc4", ifid_pc4, 32'h84);

    // Counters: 5 fetch, 2 stall, 1 flush after a fresh reset.
    rst = 1;
    tick();
    rst = 0;
    for (int i = 0; i < 5; i++) tick();
    chk("cnt_seq_pc", if_pc, 32'd20);
    chk("cnt_seq_instr", ifid_instr, mem[4]);
    stall = 1;
    tick(); tick();
    stall = 0; br_taken = 1; br_target = 32'h8;
    tick();
    br_taken = 0;
    chk("cnt_br_pc", if_pc, 32'h8);
`ifdef FETCH_PERF_CNT_EN
    chk("fetch_cnt", fetch_cnt, 32'd5);
    chk("stall_cnt", stall_cnt, 32'd2);
    chk("flush_cnt", flush_cnt, 32'd1);
`endif
    // Run one fetch so IF/ID is valid, then reset during stall+branch.
    tick();
    chk("pre_rst_valid", {31'b0, ifid_valid}, 32'd1);
    rst = 1; stall = 1; br_taken = 1; br_target = 32'h60;
    tick();
    chk("midrst_pc", if_pc, 32'h0);
    chk("midrst_valid", {31'b0, ifid_valid}, 32'd0);
    chk("midrst_instr", ifid_instr, 32'h0);
    chk("midrst_pc4", ifid_pc4, 32'h0);
`ifdef FETCH_PERF_CNT_EN
    chk("midrst_fetch_cnt", fetch_cnt, 32'd0);
    chk("midrst_stall_cnt", stall_cnt, 32'd0);
    chk("midrst_flush_cnt", flush_cnt, 32'd0);
`endif
    rst = 0; idle_inputs();
    tick();
    chk("after_rst_pc", if_pc, 32'd4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
